// File: rtl/radix4_pkg.sv
// Shared constants and state encoding for the radix-4 multiplier scheduler.
package radix4_pkg;

    localparam int unsigned OPERAND_W              = 8;
    localparam int unsigned PRODUCT_W              = 16;
    localparam int unsigned GRANT_W                = 3;
    localparam int unsigned DEFAULT_TIMEOUT_CYCLES = 64;

    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StClear  = 3'd1,
        StLaunch = 3'd2,
        StWait   = 3'd3,
        StDone   = 3'd4
    } sched_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: the requester closest above last_grant (with wrap) wins.
module rr_arbiter
    import radix4_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [GRANT_W-1:0] last_grant,
    output logic               gnt_valid,
    output logic [GRANT_W-1:0] gnt_idx
);

    int unsigned w_dist;
    int unsigned w_best;

    // Rank each requester by its distance past last_grant; keep the nearest active one.
    always_comb begin
        gnt_valid = 1'b0;
        gnt_idx   = '0;
        w_best    = NUM_REQ;
        w_dist    = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_dist = (i + NUM_REQ - 1 - int'(last_grant)) % NUM_REQ;
            if (req[i] && (w_dist < w_best)) begin
                w_best    = w_dist;
                gnt_idx   = GRANT_W'(i);
                gnt_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/radix4_mult_scheduler.sv
// Shares one radix_4 Booth multiplier between NUM_REQ requesters, round-robin.
// Optional watchdog in WAIT is enabled by defining RADIX4_SCHED_TIMEOUT_EN.
module radix4_mult_scheduler
    import radix4_pkg::*;
#(
    parameter int unsigned NUM_REQ        = 4,
    parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic                         clock,
    input  logic                         reset_n,
    input  logic [NUM_REQ-1:0]           req,
    input  logic [OPERAND_W*NUM_REQ-1:0] x_in,
    input  logic [OPERAND_W*NUM_REQ-1:0] y_in,
    output logic [NUM_REQ-1:0]           ack,
    output logic [PRODUCT_W-1:0]         product_out,
    output logic [GRANT_W-1:0]           grant_id,
    output logic                         busy,
    output logic                         err,
    output logic                         mult_reset,
    output logic                         mult_start,
    output logic [OPERAND_W-1:0]         mult_x,
    output logic [OPERAND_W-1:0]         mult_y,
    input  logic [PRODUCT_W-1:0]         mult_product,
    input  logic                         mult_ready
);

    if ((NUM_REQ < 2) || (NUM_REQ > 8) || (TIMEOUT_CYCLES < 1)) begin : g_bad_params
        $error("radix4_mult_scheduler: NUM_REQ must be 2..8 and TIMEOUT_CYCLES >= 1");
    end

    sched_state_e         r_state;
    sched_state_e         w_state_next;
    logic [GRANT_W-1:0]   r_last_grant;
    logic [GRANT_W-1:0]   r_grant;
    logic [GRANT_W-1:0]   w_gnt_idx;
    logic                 w_gnt_valid;
    logic                 w_timeout;
    logic [OPERAND_W-1:0] r_x;
    logic [OPERAND_W-1:0] r_y;
    logic [OPERAND_W-1:0] w_sel_x;
    logic [OPERAND_W-1:0] w_sel_y;
    logic [PRODUCT_W-1:0] r_product;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_arb (
        .req        (req),
        .last_grant (r_last_grant),
        .gnt_valid  (w_gnt_valid),
        .gnt_idx    (w_gnt_idx)
    );

    // Select the arbitration winner's operand pair from the packed buses.
    always_comb begin
        w_sel_x = '0;
        w_sel_y = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_gnt_idx == GRANT_W'(i)) begin
                w_sel_x = x_in[i*OPERAND_W +: OPERAND_W];
                w_sel_y = y_in[i*OPERAND_W +: OPERAND_W];
            end
        end
    end

`ifdef RADIX4_SCHED_TIMEOUT_EN
    localparam int unsigned WDOG_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [WDOG_W-1:0] r_wdog;
    logic              r_timeout;

    assign w_timeout = (r_state == StWait) && !mult_ready &&
                       (r_wdog == WDOG_W'(TIMEOUT_CYCLES - 1));

    // Watchdog: cleared on the way into WAIT, counts every WAIT cycle, flags the exit reason.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_wdog    <= '0;
            r_timeout <= 1'b0;
        end else begin
            if (r_state == StLaunch) begin
                r_wdog <= '0;
            end else if (r_state == StWait) begin
                r_wdog <= r_wdog + WDOG_W'(1);
            end
            if (r_state == StWait) begin
                r_timeout <= w_timeout;
            end
        end
    end

    assign err = (r_state == StDone) && r_timeout;
`else
    assign w_timeout = 1'b0;
    assign err       = 1'b0;
`endif

    // State, grant bookkeeping, operand latch and result capture.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= StIdle;
            r_last_grant <= GRANT_W'(NUM_REQ - 1);
            r_grant      <= '0;
            r_x          <= '0;
            r_y          <= '0;
            r_product    <= '0;
        end else begin
            r_state <= w_state_next;
            if ((r_state == StIdle) && w_gnt_valid) begin
                r_grant <= w_gnt_idx;
                r_x     <= w_sel_x;
                r_y     <= w_sel_y;
            end
            if ((r_state == StWait) && mult_ready) begin
                r_product <= mult_product;
            end else if (w_timeout) begin
                r_product <= '0;
            end
            if (r_state == StDone) begin
                r_last_grant <= r_grant;
            end
        end
    end

    // Next-state and per-state control outputs.
    always_comb begin
        w_state_next = r_state;
        ack          = '0;
        mult_start   = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (w_gnt_valid) w_state_next = StClear;
            end
            StClear: begin
                w_state_next = StLaunch;
            end
            StLaunch: begin
                mult_start   = 1'b1;
                w_state_next = StWait;
            end
            StWait: begin
                if (mult_ready || w_timeout) w_state_next = StDone;
            end
            StDone: begin
                for (int i = 0; i < NUM_REQ; i++) begin
                    ack[i] = (r_grant == GRANT_W'(i));
                end
                w_state_next = StIdle;
            end
            default: begin
                w_state_next = StIdle;
            end
        endcase
    end

    // Multiplier is held cleared while the scheduler itself is in reset.
    assign mult_reset  = ~reset_n | (r_state == StClear);
    assign busy        = (r_state != StIdle);
    assign grant_id    = r_grant;
    assign product_out = r_product;
    assign mult_x      = r_x;
    assign mult_y      = r_y;

endmodule

// File: tb/tb_radix4_mult_scheduler.sv
// Self-checking bench for radix4_mult_scheduler with a behavioural multiplier stand-in.
module tb_radix4_mult_scheduler;

    localparam int NUM_REQ = 4;
    localparam int TIMEOUT = 16;

    logic                   clock = 1'b0;
    logic                   reset_n = 1'b0;
    logic [NUM_REQ-1:0]     req = '0;
    logic [8*NUM_REQ-1:0]   x_in = '0;
    logic [8*NUM_REQ-1:0]   y_in = '0;
    logic [NUM_REQ-1:0]     ack;
    logic [15:0]            product_out;
    logic [2:0]             grant_id;
    logic                   busy;
    logic                   err;
    logic                   mult_reset;
    logic                   mult_start;
    logic [7:0]             mult_x;
    logic [7:0]             mult_y;
    logic [15:0]            mult_product;
    logic                   mult_ready;

    int errors = 0;
    int checks = 0;
    int model_last = NUM_REQ - 1;

    always #5 clock = ~clock;

    radix4_mult_scheduler #(
        .NUM_REQ        (NUM_REQ),
        .TIMEOUT_CYCLES (TIMEOUT)
    ) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .req          (req),
        .x_in         (x_in),
        .y_in         (y_in),
        .ack          (ack),
        .product_out  (product_out),
        .grant_id     (grant_id),
        .busy         (busy),
        .err          (err),
        .mult_reset   (mult_reset),
        .mult_start   (mult_start),
        .mult_x       (mult_x),
        .mult_y       (mult_y),
        .mult_product (mult_product),
        .mult_ready   (mult_ready)
    );

    // Multiplier stand-in: cleared by reset, started by start, ready sticks until next clear.
    bit          stub_never_ready = 1'b0;
    int          lat_cfg = -1;
    int          m_cnt = 0;
    bit          m_run = 1'b0;
    logic        m_ready = 1'b0;
    logic [15:0] m_prod = '0;

    always @(posedge clock) begin
        if (mult_reset) begin
            m_run   <= 1'b0;
            m_ready <= 1'b0;
            m_prod  <= '0;
            m_cnt   <= 0;
        end else if (mult_start) begin
            m_run <= 1'b1;
            m_cnt <= (lat_cfg < 0) ? int'($urandom_range(0, 5)) : lat_cfg;
        end else if (m_run && !stub_never_ready) begin
            if (m_cnt == 0) begin
                m_run   <= 1'b0;
                m_ready <= 1'b1;
                m_prod  <= 16'(mult_x) * 16'(mult_y);
            end else begin
                m_cnt <= m_cnt - 1;
            end
        end
    end

    assign mult_ready   = m_ready;
    assign mult_product = m_prod;

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1, "time limit");
    end

    // Reference arbiter: first pending requester after 'last', wrapping around.
    function automatic int rr_pick(input logic [NUM_REQ-1:0] pend, input int last);
        int c;
        for (int k = 1; k <= NUM_REQ; k++) begin
            c = (last + k) % NUM_REQ;
            if (pend[c]) return c;
        end
        return -1;
    endfunction

    task automatic set_ops(input int i, input logic [7:0] x, input logic [7:0] y);
        x_in[i*8 +: 8] = x;
        y_in[i*8 +: 8] = y;
    endtask

    task automatic apply_reset();
        reset_n = 1'b0;
        req     = '0;
        repeat (3) @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
        model_last = NUM_REQ - 1;
    endtask

    // Waits (bounded) for the next ack; returns which bit fired and the result seen with it.
    task automatic wait_ack(input int budget, output int idx, output logic [15:0] prod,
                            output logic e, output bit ok);
        int c;
        ok   = 1'b0;
        idx  = -1;
        prod = '0;
        e    = 1'b0;
        c    = 0;
        while (!ok && (c < budget)) begin
            @(negedge clock);
            c++;
            if (ack != '0) begin
                ok   = 1'b1;
                prod = product_out;
                e    = err;
                idx  = -2;
                for (int i = 0; i < NUM_REQ; i++) begin
                    if (ack == (NUM_REQ'(1) << i)) idx = i;
                end
            end
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (2) @(negedge clock);
        checks++; if (ack !== '0) begin errors++; $display("FAIL rst_ack got=%b want=0", ack); end
        checks++; if (product_out !== 16'd0) begin errors++; $display("FAIL rst_product got=%0d want=0", product_out); end
        checks++; if (grant_id !== 3'd0) begin errors++; $display("FAIL rst_grant got=%0d want=0", grant_id); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got=%b want=0", busy); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL rst_err got=%b want=0", err); end
        checks++; if (mult_start !== 1'b0) begin errors++; $display("FAIL rst_start got=%b want=0", mult_start); end
        checks++; if ({mult_x, mult_y} !== 16'd0) begin errors++; $display("FAIL rst_operands got=%h want=0", {mult_x, mult_y}); end
        checks++; if (mult_reset !== 1'b1) begin errors++; $display("FAIL rst_mult_reset got=%b want=1", mult_reset); end
        reset_n = 1'b1;
        repeat (2) @(negedge clock);
        checks++; if (mult_reset !== 1'b0) begin errors++; $display("FAIL idle_mult_reset got=%b want=0", mult_reset); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL idle_busy got=%b want=0", busy); end
        model_last = NUM_REQ - 1;
    endtask

    task automatic test_single();
        int rst_at, start_at, nrst, nstart, stray, busy_c1;
        bit got;
        logic [NUM_REQ-1:0] ack_v;
        logic [15:0] prod;
        logic e;
        rst_at = -1; start_at = -1; nrst = 0; nstart = 0; got = 0; stray = 0; busy_c1 = 0;
        ack_v = '0; prod = '0; e = 1'b0;
        set_ops(0, 8'd3, 8'd5);
        req = 4'b0001;
        for (int c = 1; (c <= 60) && !got; c++) begin
            @(negedge clock);
            if (c == 1) busy_c1 = busy;
            if (mult_reset) begin nrst++; if (rst_at < 0) rst_at = c; end
            if (mult_start) begin nstart++; if (start_at < 0) start_at = c; end
            if (ack != '0) begin got = 1; ack_v = ack; prod = product_out; e = err; end
        end
        req = '0;
        checks++; if (!got) begin errors++; $display("FAIL single_ack_seen got=none want=ack within 60 cycles"); end
        checks++; if (ack_v !== 4'b0001) begin errors++; $display("FAIL single_ack_bit got=%b want=0001", ack_v); end
        checks++; if (prod !== 16'd15) begin errors++; $display("FAIL single_product got=%0d want=15", prod); end
        checks++; if (e !== 1'b0) begin errors++; $display("FAIL single_err got=%b want=0", e); end
        checks++; if (busy_c1 != 1) begin errors++; $display("FAIL single_busy got=%0d want=1", busy_c1); end
        checks++; if (rst_at != 1) begin errors++; $display("FAIL single_clear_cycle got=%0d want=1", rst_at); end
        checks++; if (start_at != 2) begin errors++; $display("FAIL single_start_cycle got=%0d want=2", start_at); end
        checks++; if ((nrst != 1) || (nstart != 1)) begin
            errors++; $display("FAIL single_pulse_counts got=reset:%0d start:%0d want=1,1", nrst, nstart);
        end
        repeat (10) begin
            @(negedge clock);
            if (ack != '0) stray++;
        end
        checks++; if (stray != 0) begin errors++; $display("FAIL single_extra_ack got=%0d want=0", stray); end
        model_last = 0;
    endtask

    task automatic test_four();
        logic [NUM_REQ-1:0] pend;
        logic [7:0] xs [NUM_REQ];
        int exp, idx, gap;
        bit ok;
        logic [15:0] prod;
        logic e;
        apply_reset();
        for (int i = 0; i < NUM_REQ; i++) begin
            xs[i] = 8'(10 * (i + 1));
            set_ops(i, xs[i], 8'd7);
        end
        pend = '1;
        req  = '1;
        for (int j = 0; j < NUM_REQ; j++) begin
            exp = rr_pick(pend, model_last);
            wait_ack(40, idx, prod, e, ok);
            checks++; if (!ok || (idx != exp)) begin
                errors++; $display("FAIL four_order job=%0d got=%0d want=%0d", j, idx, exp);
            end
            checks++; if (prod !== 16'(xs[exp]) * 16'd7) begin
                errors++; $display("FAIL four_product job=%0d got=%0d want=%0d", j, prod, 16'(xs[exp]) * 16'd7);
            end
            if (!ok) break;
            req[idx]   = 1'b0;
            pend[idx]  = 1'b0;
            model_last = idx;
            if (pend != '0) begin
                gap = 0;
                for (int c = 0; c < 10; c++) begin
                    @(negedge clock);
                    if (busy) break;
                    gap++;
                end
                checks++; if (gap != 1) begin errors++; $display("FAIL four_idle_gap job=%0d got=%0d want=1", j, gap); end
            end
        end
        req = '0;
    endtask

    task automatic test_random();
        logic [NUM_REQ-1:0] pend;
        logic [7:0] xs [NUM_REQ];
        logic [7:0] ys [NUM_REQ];
        int exp, idx;
        bit ok;
        logic [15:0] prod;
        logic e;
        for (int r = 0; r < 6; r++) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                xs[i] = 8'($urandom_range(0, 255));
                ys[i] = 8'($urandom_range(0, 255));
                set_ops(i, xs[i], ys[i]);
            end
            pend = NUM_REQ'($urandom_range(1, (1 << NUM_REQ) - 1));
            req  = pend;
            while (pend != '0) begin
                exp = rr_pick(pend, model_last);
                wait_ack(40, idx, prod, e, ok);
                checks++; if (!ok || (idx != exp) || (prod !== 16'(xs[exp]) * 16'(ys[exp]))) begin
                    errors++;
                    $display("FAIL rand_job round=%0d got=idx:%0d prod:%0d want=idx:%0d prod:%0d",
                             r, idx, prod, exp, 16'(xs[exp]) * 16'(ys[exp]));
                end
                if (!ok) begin
                    pend = '0;
                end else begin
                    req[idx]   = 1'b0;
                    pend[idx]  = 1'b0;
                    model_last = idx;
                end
            end
            req = '0;
            repeat (3) @(negedge clock);
        end
    endtask

    task automatic test_alternate();
        int exp, idx, waited;
        bit ok, started;
        logic [15:0] prod;
        logic e;
        logic [2:0] gid;
        apply_reset();
        set_ops(1, 8'd255, 8'd255);
        set_ops(2, 8'd255, 8'd255);
        req = 4'b0110;
        for (int j = 0; j < 4; j++) begin
            exp = ((j % 2) == 0) ? 1 : 2;
            wait_ack(40, idx, prod, e, ok);
            gid = grant_id;
            checks++; if (!ok || (idx != exp) || (gid != 3'(exp))) begin
                errors++; $display("FAIL alt_grant job=%0d got=ack:%0d id:%0d want=%0d", j, idx, gid, exp);
            end
            checks++; if (prod !== 16'd65025) begin
                errors++; $display("FAIL alt_product job=%0d got=%0d want=65025", j, prod);
            end
            if (!ok) break;
            model_last = idx;
        end
        req = '0;
        repeat (3) @(negedge clock);
        // A request withdrawn after its job has started still gets its ack.
        set_ops(2, 8'd12, 8'd13);
        req = 4'b0100;
        started = 0;
        waited  = 0;
        while (!started && (waited < 20)) begin
            @(negedge clock);
            waited++;
            if (mult_start) started = 1;
        end
        req = '0;
        wait_ack(40, idx, prod, e, ok);
        checks++; if (!ok || (idx != 2) || (prod !== 16'd156)) begin
            errors++; $display("FAIL drop_req_ack got=ok:%0d idx:%0d prod:%0d want=1,2,156", ok, idx, prod);
        end
        if (ok) model_last = 2;
    endtask

    task automatic test_reset_midjob();
        int waited, stray, idx;
        bit started, ok;
        logic [15:0] prod;
        logic e;
        lat_cfg = 30;
        set_ops(3, 8'd7, 8'd11);
        req = 4'b1000;
        started = 0;
        waited  = 0;
        while (!started && (waited < 20)) begin
            @(negedge clock);
            waited++;
            if (mult_start) started = 1;
        end
        repeat (2) @(negedge clock);
        #2;
        reset_n = 1'b0;
        #1;
        checks++; if (!started || (busy !== 1'b0) || (ack !== '0)) begin
            errors++; $display("FAIL async_rst_busy_ack got=started:%0d busy:%b ack:%b want=1,0,0", started, busy, ack);
        end
        checks++; if ((grant_id !== 3'd0) || (product_out !== 16'd0)) begin
            errors++; $display("FAIL async_rst_grant_prod got=%0d,%0d want=0,0", grant_id, product_out);
        end
        checks++; if ((mult_x !== 8'd0) || (mult_y !== 8'd0) || (mult_reset !== 1'b1)) begin
            errors++; $display("FAIL async_rst_mult got=x:%0d y:%0d rst:%b want=0,0,1", mult_x, mult_y, mult_reset);
        end
        req = '0;
        repeat (3) @(negedge clock);
        reset_n    = 1'b1;
        lat_cfg    = -1;
        model_last = NUM_REQ - 1;
        stray = 0;
        repeat (40) begin
            @(negedge clock);
            if (ack != '0) stray++;
        end
        checks++; if (stray != 0) begin errors++; $display("FAIL aborted_job_ack got=%0d want=0", stray); end
        set_ops(0, 8'd2, 8'd9);
        req = 4'b0001;
        wait_ack(40, idx, prod, e, ok);
        req = '0;
        checks++; if (!ok || (idx != 0) || (prod !== 16'd18)) begin
            errors++; $display("FAIL post_rst_job got=ok:%0d idx:%0d prod:%0d want=1,0,18", ok, idx, prod);
        end
        model_last = 0;
        repeat (3) @(negedge clock);
    endtask

    task automatic test_watchdog();
        int waited;
        bit started;
        stub_never_ready = 1'b1;
        set_ops(0, 8'd4, 8'd4);
        req = 4'b0001;
        started = 0;
        waited  = 0;
        while (!started && (waited < 20)) begin
            @(negedge clock);
            waited++;
            if (mult_start) started = 1;
        end
        checks++; if (!started) begin errors++; $display("FAIL wdog_start got=none want=mult_start"); end
`ifdef RADIX4_SCHED_TIMEOUT_EN
        begin
            int ack_at;
            logic e_v;
            logic [15:0] p_v;
            ack_at = -1;
            e_v = 1'b0;
            p_v = 16'hffff;
            for (int c = 1; (c <= 40) && (ack_at < 0); c++) begin
                @(negedge clock);
                if (ack != '0) begin
                    ack_at = c;
                    e_v = err;
                    p_v = product_out;
                end
            end
            req = '0;
            checks++; if (ack_at != TIMEOUT + 1) begin
                errors++; $display("FAIL wdog_ack_cycle got=%0d want=%0d", ack_at, TIMEOUT + 1);
            end
            checks++; if ((e_v !== 1'b1) || (p_v !== 16'd0)) begin
                errors++; $display("FAIL wdog_err_product got=err:%b prod:%0d want=1,0", e_v, p_v);
            end
        end
`else
        begin
            int busy_low, err_high, acks;
            busy_low = 0;
            err_high = 0;
            acks     = 0;
            repeat (100) begin
                @(negedge clock);
                if (!busy) busy_low++;
                if (err) err_high++;
                if (ack != '0) acks++;
            end
            req = '0;
            checks++; if (busy_low != 0) begin errors++; $display("FAIL wdog_off_busy got=%0d low cycles want=0", busy_low); end
            checks++; if ((err_high != 0) || (acks != 0)) begin
                errors++; $display("FAIL wdog_off_err_ack got=err:%0d ack:%0d want=0,0", err_high, acks);
            end
        end
`endif
        stub_never_ready = 1'b0;
        apply_reset();
    endtask

    initial begin
        test_reset();
        test_single();
        test_four();
        test_random();
        test_alternate();
        test_reset_midjob();
        test_watchdog();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/radix4_mult_scheduler.md
# radix4_mult_scheduler

Round-robin scheduler that shares one `radix_4` 8x8 Booth multiplier between `NUM_REQ` requesters. For each job it clears the multiplier, launches it with the granted requester's operands and waits for `ready`. It then returns the 16-bit product to that requester with a one-cycle acknowledge. It sits between client blocks and the single multiplier instance and owns all of the multiplier's control pins.

## Interface
- `NUM_REQ`, default 4: number of requesters, 2..8.
- `TIMEOUT_CYCLES`, default 64: watchdog limit in WAIT. Used only when the watchdog macro is defined.
- `clock` in 1: single clock; all logic on its rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `req` in NUM_REQ: per-requester request level.
- `x_in` in 8*NUM_REQ: packed multiplicands; requester i uses bits [8i+7:8i].
- `y_in` in 8*NUM_REQ: packed multipliers, same packing as `x_in`.
- `ack` out NUM_REQ: one-hot, one-cycle completion pulse.
- `product_out` out 16: result, valid in the `ack` cycle, held until the next completion.
- `grant_id` out 3: index of the requester being served.
- `busy` out 1: high in every state except IDLE.
- `err` out 1: timeout flag, pulses together with `ack`.
- `mult_reset` out 1: to multiplier `reset`, active-high.
- `mult_start` out 1: to multiplier `start`.
- `mult_x`, `mult_y` out 8 each: operands to the multiplier.
- `mult_product` in 16: from multiplier `total_product`.
- `mult_ready` in 1: from multiplier `ready`.

## Operation
- States: IDLE, CLEAR, LAUNCH, WAIT, DONE.
- **IDLE:** if any `req` bit is high, pick the winner round-robin, searching from `last_grant+1` upward with wrap-around.
  - Latch the winner's x/y into the operand registers and set `grant_id`.
  - Go to CLEAR.
- **CLEAR:** `mult_reset`=1 for one cycle. The multiplier accumulates and never leaves its done state on its own, so this clear is mandatory before every job. Go to LAUNCH.
- **LAUNCH:** `mult_start`=1 for one cycle. Go to WAIT.
- **WAIT:** hold `mult_x`/`mult_y` stable, because the multiplier reads its operands live on every cycle.
  - On `mult_ready`=1, capture `mult_product` and go to DONE.
- **DONE:** pulse `ack[grant_id]`, drive the captured result on `product_out`, update `last_grant`, and go to IDLE.
- Requester rules:
  - Hold `req` until `ack`.
  - Dropping `req` after grant does not abort the job; the `ack` still pulses and is ignored.
  - `req` still high in the cycle after `ack` counts as a new request and is arbitrated fairly against the others.
- Arithmetic is unsigned 8x8 to 16 bits; 255*255 = 65025. The scheduler performs no arithmetic itself.
- `mult_reset` = `~reset_n` OR (state==CLEAR), so the multiplier is also cleared while the scheduler is in reset.
- Reset values:
  - State IDLE; `last_grant`=NUM_REQ-1, so requester 0 wins first.
  - `ack`=0, `product_out`=0, `grant_id`=0, `busy`=0, `err`=0.
  - `mult_start`=0, `mult_x`=0, `mult_y`=0.
- Reset mid-job aborts immediately; no `ack` is issued for the aborted job.

## Timing
- `req` is sampled high in IDLE at edge N:
  - CLEAR at N+1.
  - LAUNCH at N+2.
  - WAIT from N+3.
- `mult_ready` is seen at edge M; `ack` and `product_out` are valid in cycle M+1.
- Controller overhead is 4 cycles on top of multiplier latency.
- Back-to-back jobs: the next grant can occur in the first IDLE cycle after DONE, so there is at least one idle cycle between jobs.
- `ack` is never asserted on more than one bit at a time.

## Configuration
- `RADIX4_SCHED_TIMEOUT_EN` defined:
  - A cycle counter runs in WAIT.
  - If `TIMEOUT_CYCLES` cycles elapse without `mult_ready`, go to DONE with `product_out`=0 and `err`=1, pulsed together with `ack`.
  - The counter clears on entry to WAIT.
- Not defined:
  - WAIT waits indefinitely.
  - `err` is tied to 0 and no counter logic is generated.

## Structure
- Shared package `radix4_pkg` holds:
  - State encoding constants.
  - `OPERAND_W`=8 and `PRODUCT_W`=16.
  - The default `TIMEOUT_CYCLES`.
- Sub-module `rr_arbiter`: combinational round-robin pick.
  - Inputs: `req`, `last_grant`.
  - Outputs: `gnt_valid`, `gnt_idx`.
- The scheduler FSM, operand registers and optional watchdog live in the top module.

## Test plan
- Single requester, with the real `radix_4` instance:
  - `req[0]`, x=3, y=5: exactly one `ack[0]` with `product_out`=15; `mult_reset` high exactly one cycle before `mult_start`.
- Four requests raised in the same cycle, each requester j (1..4) with x=10*j, y=7:
  - Acks in order 0,1,2,3 with products 70, 140, 210, 280.
  - `busy` low for exactly one cycle between jobs.
- `req[1]` and `req[2]` both held high continuously:
  - Grants alternate 1,2,1,2.
  - x=255, y=255 on both gives `product_out`=65025 every time.
- `reset_n` pulsed low during WAIT:
  - All outputs return to reset values asynchronously and no `ack` is issued.
  - After release, a fresh `req[0]` with x=2, y=9 returns 18.
- Watchdog, with the macro defined, `TIMEOUT_CYCLES`=16, and a stub multiplier that never asserts ready:
  - `ack[0]` and `err` pulse together 16 cycles after entering WAIT, with `product_out`=0.
  - With the macro undefined, `busy` stays high and `err` stays 0.
